// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the rv_mem_resp memory responder.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } rv_mem_state_t;

  localparam int unsigned RV_XLEN = 32;
  localparam logic [RV_XLEN-1:0] RV_NOP = 32'h0000_0013;

  // A byte address hits the RAM only when every bit above the word index is zero.
  function automatic logic in_range(input logic [RV_XLEN-1:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == '0;
  endfunction

endpackage

// File: rtl/rv_mem_loader.sv
// Program-loader FSM for rv_mem_resp: accepts valid/ready words into RAM while
// holding the core in reset, then releases it once the last word is taken.
module rv_mem_loader
  import rv_mem_pkg::*;
#(
  parameter int unsigned DPWIDTH = 32,
  parameter int unsigned AW      = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [AW-1:0]      i_ld_addr,
  input  logic [DPWIDTH-1:0] i_ld_data,
  input  logic               i_ld_last,
  output logic               o_core_rst,
  output logic               o_run,
  output logic               o_we,
  output logic [AW-1:0]      o_waddr,
  output logic [DPWIDTH-1:0] o_wdata
);

  rv_mem_state_t r_state;
  rv_mem_state_t w_next;

  assign o_waddr = i_ld_addr;
  assign o_wdata = i_ld_data;

  // State register; synchronous reset always returns to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and Moore-style handshake/reset outputs; a word is accepted
  // (and written) in IDLE as well as LOAD.
  always_comb begin
    w_next     = r_state;
    o_ld_ready = 1'b0;
    o_core_rst = 1'b0;
    o_run      = 1'b0;
    o_we       = 1'b0;
    unique case (r_state)
      IDLE, LOAD: begin
        o_ld_ready = 1'b1;
        o_core_rst = 1'b1;
        o_we       = i_ld_valid;
        if (i_ld_valid) w_next = i_ld_last ? RUN : LOAD;
      end
      RUN: begin
        o_run = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/rv_mem_resp.sv
// Unified word RAM serving the multicycle core's imem/dmem ports, with a
// program loader and sticky access-error reporting.
// Optional feature macro: RV_MEM_MMIO_EN adds a tohost register at MMIO_ADDR.
module rv_mem_resp
  import rv_mem_pkg::*;
#(
  parameter int unsigned  DPWIDTH   = 32,
  parameter int unsigned  MEMWORDS  = 1024,
  parameter logic [DPWIDTH-1:0] MMIO_ADDR = 32'hFFFF_FFF0,
  localparam int unsigned AW        = $clog2(MEMWORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] imem_addr,
  output logic [DPWIDTH-1:0] imem_datain,
  input  logic [DPWIDTH-1:0] dmem_addr,
  input  logic [DPWIDTH-1:0] dmem_dataout,
  input  logic               memrw,
  output logic [DPWIDTH-1:0] dmem_datain,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_addr,
  input  logic [DPWIDTH-1:0] ld_data,
  input  logic               ld_last,
  output logic               core_rst,
  output logic               err_misalign,
  output logic               err_range,
`ifdef RV_MEM_MMIO_EN
  output logic [DPWIDTH-1:0] err_addr,
  output logic [DPWIDTH-1:0] tohost,
  output logic               tohost_valid
`else
  output logic [DPWIDTH-1:0] err_addr
`endif
);

`ifdef RV_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic [DPWIDTH-1:0] r_mem [MEMWORDS];

  logic               w_run;
  logic               w_ld_we;
  logic [AW-1:0]      w_ld_waddr;
  logic [DPWIDTH-1:0] w_ld_wdata;

  logic [AW-1:0]      w_i_idx;
  logic [AW-1:0]      w_d_idx;
  logic               w_i_inr;
  logic               w_d_inr;
  logic               w_d_mmio;
  logic               w_core_we;
  logic               w_mmio_we;
  logic               w_i_mis;
  logic               w_i_rng;
  logic               w_d_mis;
  logic               w_d_rng;
  logic               w_d_err;
  logic               w_any_err;
  logic [DPWIDTH-1:0] w_tohost;

  logic               r_err_misalign;
  logic               r_err_range;
  logic [DPWIDTH-1:0] r_err_addr;

  rv_mem_loader #(
    .DPWIDTH (DPWIDTH),
    .AW      (AW)
  ) u_loader (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ld_valid (ld_valid),
    .o_ld_ready (ld_ready),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .i_ld_last  (ld_last),
    .o_core_rst (core_rst),
    .o_run      (w_run),
    .o_we       (w_ld_we),
    .o_waddr    (w_ld_waddr),
    .o_wdata    (w_ld_wdata)
  );

  assign w_i_idx  = imem_addr[AW+1:2];
  assign w_d_idx  = dmem_addr[AW+1:2];
  assign w_i_inr  = in_range(imem_addr, AW);
  assign w_d_inr  = in_range(dmem_addr, AW);
  assign w_d_mmio = MMIO_EN && (dmem_addr == MMIO_ADDR);

  // Core write path: RUN only, aligned, in range; MMIO writes never reach RAM.
  assign w_core_we = w_run && memrw && w_d_inr && (dmem_addr[1:0] == 2'b00) && !w_d_mmio;
  assign w_mmio_we = w_run && memrw && w_d_mmio;

  // Error qualification: imem is always checked, dmem only on writes; the
  // MMIO address is a legal target and so is not a range error.
  assign w_i_mis   = imem_addr[1:0] != 2'b00;
  assign w_i_rng   = !w_i_inr;
  assign w_d_mis   = memrw && (dmem_addr[1:0] != 2'b00);
  assign w_d_rng   = memrw && !w_d_inr && !w_d_mmio;
  assign w_d_err   = w_d_mis || w_d_rng;
  assign w_any_err = w_d_err || w_i_mis || w_i_rng;

  // RAM write port shared by loader and core; their enables are mode-exclusive.
  // No reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_ld_we)        r_mem[w_ld_waddr] <= w_ld_wdata;
    else if (w_core_we) r_mem[w_d_idx]    <= dmem_dataout;
  end

  // Combinational reads; a same-cycle write is not visible until the next cycle.
  always_comb begin
    imem_datain = w_i_inr ? r_mem[w_i_idx] : RV_NOP;
    if (w_d_mmio)     dmem_datain = w_tohost;
    else if (w_d_inr) dmem_datain = r_mem[w_d_idx];
    else              dmem_datain = '0;
  end

  // Sticky error flags; err_addr latches only the first offending cycle,
  // with dmem taking priority when both ports fault together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_misalign <= 1'b0;
      r_err_range    <= 1'b0;
      r_err_addr     <= '0;
    end else if (w_run) begin
      if (w_i_mis || w_d_mis) r_err_misalign <= 1'b1;
      if (w_i_rng || w_d_rng) r_err_range    <= 1'b1;
      if (w_any_err && !(r_err_misalign || r_err_range))
        r_err_addr <= w_d_err ? dmem_addr : imem_addr;
    end
  end

  assign err_misalign = r_err_misalign;
  assign err_range    = r_err_range;
  assign err_addr     = r_err_addr;

`ifdef RV_MEM_MMIO_EN
  logic [DPWIDTH-1:0] r_tohost;
  logic               r_tohost_valid;

  // tohost register; valid pulses for the single cycle after each MMIO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost       <= '0;
      r_tohost_valid <= 1'b0;
    end else begin
      r_tohost_valid <= w_mmio_we;
      if (w_mmio_we) r_tohost <= dmem_dataout;
    end
  end

  assign w_tohost     = r_tohost;
  assign tohost       = r_tohost;
  assign tohost_valid = r_tohost_valid;
`else
  assign w_tohost = {{(DPWIDTH-1){1'b0}}, w_mmio_we};
`endif

endmodule

// File: tb/tb_rv_mem_resp.sv
// Scoreboard bench for rv_mem_resp: stimulus queues expected output values for
// the current cycle; a monitor compares them mid-cycle on the falling edge.
module tb_rv_mem_resp;
  import rv_mem_pkg::*;

  localparam int unsigned MW = 1024;
  localparam int unsigned AW = $clog2(MW);

  typedef enum int {S_IMEM, S_DMEM, S_CORE_RST, S_LD_READY, S_ERR_MIS, S_ERR_RNG,
                    S_ERR_ADDR, S_TOHOST, S_TOHOST_V} sel_t;
  typedef struct {
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_datain, dmem_addr, dmem_dataout, dmem_datain;
  logic        memrw, ld_valid, ld_ready, ld_last, core_rst, err_misalign, err_range;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_data, err_addr;
  logic [31:0] tohost;
  logic        tohost_valid;

  item_t sb[$];
  item_t it;
  logic [31:0] act;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_mem_resp #(.DPWIDTH(32), .MEMWORDS(MW), .MMIO_ADDR(32'hFFFF_FFF0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_datain  (imem_datain),
    .dmem_addr    (dmem_addr),
    .dmem_dataout (dmem_dataout),
    .memrw        (memrw),
    .dmem_datain  (dmem_datain),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .core_rst     (core_rst),
    .err_misalign (err_misalign),
    .err_range    (err_range),
`ifdef RV_MEM_MMIO_EN
    .err_addr     (err_addr),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
`else
    .err_addr     (err_addr)
`endif
  );

`ifndef RV_MEM_MMIO_EN
  assign tohost       = '0;
  assign tohost_valid = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input sel_t s, input logic [31:0] v, input string n);
    item_t x;
    x.sel = s; x.exp = v; x.name = n;
    sb.push_back(x);
  endtask

  // Monitor: drain every expectation queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sel)
        S_IMEM:     act = imem_datain;
        S_DMEM:     act = dmem_datain;
        S_CORE_RST: act = {31'd0, core_rst};
        S_LD_READY: act = {31'd0, ld_ready};
        S_ERR_MIS:  act = {31'd0, err_misalign};
        S_ERR_RNG:  act = {31'd0, err_range};
        S_ERR_ADDR: act = err_addr;
        S_TOHOST:   act = tohost;
        default:    act = {31'd0, tohost_valid};
      endcase
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_addr = '0; dmem_addr = '0; dmem_dataout = '0; memrw = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    step(); step();
    exp_push(S_CORE_RST, 32'd1, "rst_core_rst");
    exp_push(S_LD_READY, 32'd1, "rst_ld_ready");
    exp_push(S_ERR_MIS,  32'd0, "rst_err_mis");
    exp_push(S_ERR_RNG,  32'd0, "rst_err_rng");
    exp_push(S_ERR_ADDR, 32'd0, "rst_err_addr");
    step();

    // Load three words
    rst = 1'b0; ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'h0050_0093;
    exp_push(S_LD_READY, 32'd1, "ld_ready_idle");
    step();
    ld_addr = 10'd1; ld_data = 32'h00A0_0113;
    step();
    ld_addr = 10'd2; ld_data = 32'h0020_81B3; ld_last = 1'b1;
    exp_push(S_CORE_RST, 32'd1, "core_rst_last_cycle");
    step();
    ld_valid = 1'b0; ld_last = 1'b0; imem_addr = 32'h4; dmem_addr = 32'h8;
    exp_push(S_CORE_RST, 32'd0, "core_rst_released");
    exp_push(S_LD_READY, 32'd0, "ld_ready_run");
    exp_push(S_IMEM, 32'h00A0_0113, "imem_word1");
    exp_push(S_DMEM, 32'h0020_81B3, "dmem_word2");
    step();

    // Core writes and read-during-write
    memrw = 1'b1; dmem_addr = 32'h100; dmem_dataout = 32'h1111_1111;
    step();
    dmem_dataout = 32'hDEAD_BEEF; imem_addr = 32'h100;
    exp_push(S_DMEM, 32'h1111_1111, "rdw_dmem_old");
    exp_push(S_IMEM, 32'h1111_1111, "rdw_imem_old");
    step();
    memrw = 1'b0; dmem_addr = 32'h103;
    exp_push(S_DMEM, 32'hDEAD_BEEF, "dmem_new_misaligned_read");
    exp_push(S_IMEM, 32'hDEAD_BEEF, "imem_new");
    exp_push(S_ERR_MIS, 32'd0, "no_err_on_read");
    exp_push(S_ERR_RNG, 32'd0, "no_rng_err_yet");
    step();

    // Misaligned write, then range errors
    memrw = 1'b1; dmem_addr = 32'h102; dmem_dataout = 32'h1234_5678; imem_addr = 32'h0;
    step();
    memrw = 1'b0; dmem_addr = 32'h100;
    exp_push(S_DMEM, 32'hDEAD_BEEF, "misaligned_write_dropped");
    exp_push(S_ERR_MIS, 32'd1, "err_misalign_set");
    exp_push(S_ERR_ADDR, 32'h102, "err_addr_first");
    exp_push(S_ERR_RNG, 32'd0, "err_range_clear");
    step();
    imem_addr = 4 * MW;
    exp_push(S_IMEM, RV_NOP, "imem_oor_nop");
    step();
    imem_addr = 32'h0; dmem_addr = 32'h0001_0000;
    exp_push(S_ERR_RNG, 32'd1, "err_range_set");
    exp_push(S_ERR_ADDR, 32'h102, "err_addr_kept");
    exp_push(S_DMEM, 32'h0, "dmem_oor_zero");
    exp_push(S_IMEM, 32'h0050_0093, "imem_word0");
    step();
    memrw = 1'b1; dmem_dataout = 32'hFFFF_FFFF;
    step();
    memrw = 1'b0; dmem_addr = 32'h0;
    exp_push(S_DMEM, 32'h0050_0093, "oor_write_dropped");
    step();

    // Reset clears errors, keeps RAM
    rst = 1'b1;
    step();
    rst = 1'b0; imem_addr = 32'h4; dmem_addr = 32'h100;
    exp_push(S_ERR_MIS, 32'd0, "rst2_err_mis");
    exp_push(S_ERR_RNG, 32'd0, "rst2_err_rng");
    exp_push(S_ERR_ADDR, 32'd0, "rst2_err_addr");
    exp_push(S_CORE_RST, 32'd1, "rst2_core_rst");
    exp_push(S_IMEM, 32'h00A0_0113, "ram_kept_word1");
    exp_push(S_DMEM, 32'hDEAD_BEEF, "ram_kept_0x100");
    memrw = 1'b1; dmem_dataout = 32'hBAD0_BAD0;
    step();

    // Reset mid-load
    memrw = 1'b0; ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hCAFE_0001;
    exp_push(S_DMEM, 32'hDEAD_BEEF, "idle_memrw_ignored");
    step();
    ld_valid = 1'b0; rst = 1'b1;
    exp_push(S_LD_READY, 32'd1, "ld_ready_load");
    step();
    rst = 1'b0; imem_addr = 32'h0; dmem_addr = 32'h4;
    exp_push(S_LD_READY, 32'd1, "midload_rst_ready");
    exp_push(S_CORE_RST, 32'd1, "midload_rst_core_rst");
    exp_push(S_IMEM, 32'hCAFE_0001, "midload_word0_kept");
    exp_push(S_DMEM, 32'h00A0_0113, "midload_word1_kept");
    step();
    ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'h0000_0055; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; imem_addr = 32'h14;
    exp_push(S_CORE_RST, 32'd0, "reload_released");
    exp_push(S_IMEM, 32'h0000_0055, "reload_word5");
    step();

    // MMIO address write with simultaneous imem misalignment
    memrw = 1'b1; dmem_addr = 32'hFFFF_FFF0; dmem_dataout = 32'h1; imem_addr = 32'h2;
    exp_push(S_IMEM, 32'hCAFE_0001, "imem_misaligned_read");
    step();
    memrw = 1'b0; imem_addr = 32'h0;
    exp_push(S_ERR_MIS, 32'd1, "imem_misalign_flag");
`ifdef RV_MEM_MMIO_EN
    exp_push(S_TOHOST, 32'h1, "tohost_loaded");
    exp_push(S_TOHOST_V, 32'd1, "tohost_valid_pulse");
    exp_push(S_ERR_RNG, 32'd0, "mmio_no_range_err");
    exp_push(S_ERR_ADDR, 32'h2, "err_addr_imem");
    exp_push(S_DMEM, 32'h1, "mmio_readback");
    step();
    exp_push(S_TOHOST_V, 32'd0, "tohost_valid_single");
    exp_push(S_TOHOST, 32'h1, "tohost_held");
`else
    exp_push(S_ERR_RNG, 32'd1, "mmio_addr_range_err");
    exp_push(S_ERR_ADDR, 32'hFFFF_FFF0, "err_addr_dmem_wins");
    exp_push(S_DMEM, 32'h0, "mmio_addr_read_zero");
`endif
    step();
    step();

    n_tests++;
    if (err_misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL final_err_misalign_sticky: got %b expected 1", err_misalign);
    end
    n_tests++;
    if (core_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL final_core_rst_run: got %b expected 0", core_rst);
    end
    n_tests++;
    if (ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL final_ld_ready_run: got %b expected 0", ld_ready);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail != 0) $display("FAIL overall");
    else             $display("PASS");
    $finish;
  end

endmodule
